// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit: 8 bitwise functions feeding a 2-entry result queue with valid/ready on both sides.
// Optional LOGIC_UNIT_FLAGS_EN adds per-entry zero and parity flags on the output side.
module bitwise_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] mem [2];
  logic [1:0]       count;
  logic             head;
  logic             tail;
  logic             push;
  logic             pop;

  always_comb begin
    result = '0;
    case (in_op)
      3'b000:  result = in_a & in_b;
      3'b001:  result = in_a | in_b;
      3'b010:  result = in_a ^ in_b;
      3'b011:  result = ~(in_a & in_b);
      3'b100:  result = ~(in_a | in_b);
      3'b101:  result = ~(in_a ^ in_b);
      3'b110:  result = ~in_a;
      default: result = in_a;
    endcase
  end

  // ready/valid depend only on the registered occupancy
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_y     = mem[head];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= result;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_q   [2];
  logic parity_q [2];

  assign out_zero   = zero_q[head];
  assign out_parity = parity_q[head];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q[0]   <= 1'b1;
      zero_q[1]   <= 1'b1;
      parity_q[0] <= 1'b0;
      parity_q[1] <= 1'b0;
    end else if (push) begin
      zero_q[tail]   <= (result == '0);
      parity_q[tail] <= ^result;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit (WIDTH=8): vector table, hand sequences and a random scoreboard run.
// Flag checks are compiled in when LOGIC_UNIT_FLAGS_EN is defined.
module tb_bitwise_logic_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic       out_zero;
  logic       out_parity;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [8];

  bitwise_logic_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Reference: each opcode is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [3:0] tt [8];
    logic [7:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Check outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    bit         do_push;
    bit         do_pop;
    logic [7:0] r;
    chk("in_ready", in_ready, (exp_q.size() < 2));
    chk("out_valid", out_valid, (exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("out_y", out_y, exp_q[0]);
`ifdef LOGIC_UNIT_FLAGS_EN
      chk("out_zero", out_zero, (exp_q[0] == 8'h00));
      chk("out_parity", out_parity, ($countones(exp_q[0]) % 2));
`endif
    end
    do_push = rst_n && in_valid && (exp_q.size() < 2);
    do_pop  = rst_n && out_ready && (exp_q.size() > 0);
    r = ref_op(in_a, in_b, in_op);
    @(posedge clk);
    if (!rst_n) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(r);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'h0F, 3'b000, 8'h05};
    vecs[1] = '{8'hA5, 8'h0F, 3'b001, 8'hAF};
    vecs[2] = '{8'hA5, 8'h0F, 3'b010, 8'hAA};
    vecs[3] = '{8'hA5, 8'h0F, 3'b011, 8'hFA};
    vecs[4] = '{8'hA5, 8'h0F, 3'b100, 8'h50};
    vecs[5] = '{8'hA5, 8'h0F, 3'b101, 8'h55};
    vecs[6] = '{8'hA5, 8'h0F, 3'b110, 8'h5A};
    vecs[7] = '{8'hA5, 8'h0F, 3'b111, 8'hA5};

    // 1: reset, idle, single AND
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    @(posedge clk);
    #1;
    cycle();
    rst_n = 1'b1;
    chk("rst_out_y", out_y, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef LOGIC_UNIT_FLAGS_EN
    chk("rst_out_zero", out_zero, 1'b1);
    chk("rst_out_parity", out_parity, 1'b0);
`endif
    cycle();
    drive(1'b1, 8'hF0, 8'h3C, 3'b000);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    chk("and_valid", out_valid, 1'b1);
    chk("and_y", out_y, 8'h30);
    out_ready = 1'b1;
    cycle();
    cycle();

    // 2: opcode sweep, one result per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      cycle();
      chk("sweep_y", out_y, vecs[i].exp);
      chk("sweep_valid", out_valid, 1'b1);
    end
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    cycle();
    cycle();

    // 3: backpressure fills the queue; third push is dropped
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h03, 3'b010);
    cycle();
    drive(1'b1, 8'h10, 8'h01, 3'b001);
    cycle();
    chk("full_in_ready", in_ready, 1'b0);
    drive(1'b1, 8'hFF, 8'hFF, 3'b000);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    cycle();
    chk("bp_hold_y", out_y, 8'h02);
    out_ready = 1'b1;
    chk("bp_first_y", out_y, 8'h02);
    cycle();
    chk("bp_second_y", out_y, 8'h11);
    chk("bp_ready_back", in_ready, 1'b1);
    cycle();
    chk("bp_drained", out_valid, 1'b0);
    cycle();

    // 4: continuous push/pop at occupancy 1
    drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
    cycle();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
      cycle();
      chk("stream_count1_valid", out_valid, 1'b1);
      chk("stream_count1_ready", in_ready, 1'b1);
    end
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    cycle();
    cycle();

    // 5: reset with a full queue and in_valid asserted
    out_ready = 1'b0;
    drive(1'b1, 8'h3C, 8'hC3, 3'b001);
    cycle();
    drive(1'b1, 8'h55, 8'hAA, 3'b010);
    cycle();
    rst_n = 1'b0;
    drive(1'b1, 8'h12, 8'h34, 3'b111);
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_y", out_y, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

`ifdef LOGIC_UNIT_FLAGS_EN
    // 6: flag values
    out_ready = 1'b0;
    drive(1'b1, 8'h0F, 8'hF0, 3'b000);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    chk("flag_and_y", out_y, 8'h00);
    chk("flag_and_zero", out_zero, 1'b1);
    chk("flag_and_parity", out_parity, 1'b0);
    out_ready = 1'b1;
    cycle();
    drive(1'b1, 8'h07, 8'h00, 3'b001);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    chk("flag_or_y", out_y, 8'h07);
    chk("flag_or_zero", out_zero, 1'b0);
    chk("flag_or_parity", out_parity, 1'b1);
    cycle();
`endif

    // Random traffic with random stalls against the scoreboard
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
